branch_resolve_unit: RTL and testbench

Parametrised EX-stage branch/jump resolution unit for the 5-stage RISC-V pipeline. It evaluates all RV conditional branches plus JAL/JALR, computes the target and link address, and compares the outcome against the fetch-stage prediction. A registered redirect is driven to the pipeline one cycle later. It also owns a 2-bit-counter branch history table (BHT) read by IF, plus saturating branch and mispredict statistics counters.

---
 rtl/branch_resolve_unit.sv | 175 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   EX-stage resolution of RISC-V conditional branches, JAL and JALR.
//   It computes the outcome, target and link address, and compares them with
//   the fetch-stage prediction. A registered redirect goes to the pipeline one
//   cycle after accept. The unit also owns a BHT of 2-bit saturating counters
//   that IF reads, plus saturating branch and mispredict statistics counters.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   ex_valid/stall/flush EX handshake; flush has priority over stall
//   ex_is_branch/jal/jalr instruction class (priority jalr > jal > branch)
//   ex_funct3           branch condition
//   ex_pc, ex_imm       instruction PC, sign-extended immediate
//   ex_rs1, ex_rs2      forwarded operands
//   ex_pred_taken/target prediction made at fetch
//   if_pc               fetch PC for the BHT lookup
//   if_pred_taken       combinational BHT prediction for if_pc
//   res_valid/res_taken registered resolution
//   redirect_valid/pc   registered mispredict redirect
//   link_data           registered pc+4
//   illegal_branch      registered: funct3 010/011 on a branch
//   branch_cnt, mispred_cnt saturating statistics
module branch_resolve_unit #(
  parameter int XLEN        = 64,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_flush,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  link_data,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic            sel_jalr, sel_jal, sel_br, accept;
  logic            cond_taken, illegal, taken, mispredict;
  logic [XLEN-1:0] pc_plus4, target, next_pc;
  logic [IDX_W-1:0] ex_idx, if_idx;
  logic [1:0]      ctr_old;

  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0]  link_data_q, link_data_d;
  logic             illegal_branch_q, illegal_branch_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];

  // Resolution datapath
  always_comb begin
    sel_jalr   = ex_is_jalr;
    sel_jal    = ex_is_jal & ~ex_is_jalr;
    sel_br     = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
    accept     = ex_valid & ~ex_flush & ~ex_stall & (sel_jalr | sel_jal | sel_br);
    cond_taken = 1'b0;
    illegal    = 1'b0;
    case (ex_funct3)
      3'b000:  cond_taken = (ex_rs1 == ex_rs2);
      3'b001:  cond_taken = (ex_rs1 != ex_rs2);
      3'b100:  cond_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  cond_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cond_taken = (ex_rs1 <  ex_rs2);
      3'b111:  cond_taken = (ex_rs1 >= ex_rs2);
      default: illegal    = sel_br;
    endcase
    taken    = sel_jalr | sel_jal | (sel_br & cond_taken);
    pc_plus4 = ex_pc + XLEN'(4);
    if (sel_jalr) target = (ex_rs1 + ex_imm) & {{(XLEN-1){1'b1}}, 1'b0};
    else          target = ex_pc + ex_imm;
    next_pc    = taken ? target : pc_plus4;
    mispredict = (ex_pred_taken != taken) | (taken & (ex_pred_target != target));
  end

  // BHT lookup sees the registered array, so a same-cycle update is not visible
  always_comb begin
    if_idx        = if_pc[IDX_W+1:2];
    if_pred_taken = bht_q[if_idx][1];
  end

  // Next-state: flush clears valids, stall holds everything, otherwise
  // valids follow accept and data registers load only on accept.
  always_comb begin
    res_valid_d      = res_valid_q;
    res_taken_d      = res_taken_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    link_data_d      = link_data_q;
    illegal_branch_d = illegal_branch_q;
    branch_cnt_d     = branch_cnt_q;
    mispred_cnt_d    = mispred_cnt_q;
    bht_d            = bht_q;
    ex_idx           = ex_pc[IDX_W+1:2];
    ctr_old          = bht_q[ex_idx];
    if (ex_flush || !ex_stall) begin
      res_valid_d      = 1'b0;
      redirect_valid_d = 1'b0;
      illegal_branch_d = 1'b0;
    end
    if (accept) begin
      res_valid_d      = 1'b1;
      res_taken_d      = taken;
      redirect_valid_d = mispredict;
      redirect_pc_d    = next_pc;
      link_data_d      = pc_plus4;
      illegal_branch_d = illegal;
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
      if (sel_br) begin
        if (taken && (ctr_old != 2'b11))       bht_d[ex_idx] = ctr_old + 2'd1;
        else if (!taken && (ctr_old != 2'b00)) bht_d[ex_idx] = ctr_old - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      link_data_q      <= '0;
      illegal_branch_q <= 1'b0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      res_valid_q      <= res_valid_d;
      res_taken_q      <= res_taken_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      link_data_q      <= link_data_d;
      illegal_branch_q <= illegal_branch_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= bht_d[i];
    end
  end

  always_comb begin
    res_valid      = res_valid_q;
    res_taken      = res_taken_q;
    redirect_valid = redirect_valid_q;
    redirect_pc    = redirect_pc_q;
    link_data      = link_data_q;
    illegal_branch = illegal_branch_q;
    branch_cnt     = branch_cnt_q;
    mispred_cnt    = mispred_cnt_q;
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam int XLEN = 64;
  localparam int BHT  = 64;
  localparam int CW   = 4;
  localparam int CMAX = 15;
  localparam int NONE = 0, BR = 1, JAL = 2, JALR = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid, ex_stall, ex_flush;
  logic            ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_target, if_pc;
  logic            ex_pred_taken;
  logic            if_pred_taken, res_valid, res_taken, redirect_valid, illegal_branch;
  logic [XLEN-1:0] redirect_pc, link_data;
  logic [CW-1:0]   branch_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(BHT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .res_valid(res_valid), .res_taken(res_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .link_data(link_data),
    .illegal_branch(illegal_branch), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic            taken;
    logic            redir;
    logic            illegal;
    logic [XLEN-1:0] rpc;
    logic [XLEN-1:0] link;
  } exp_t;

  exp_t sb[$];
  int   m_bht[BHT];
  int   m_bcnt, m_mcnt;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < BHT; i++) m_bht[i] = 1;
    m_bcnt = 0;
    m_mcnt = 0;
    sb.delete();
  endtask

  // Reference: outcome from the ISA rules, applied at the clock edge
  task automatic model_edge();
    exp_t            e;
    logic [XLEN-1:0] tgt;
    bit              tk, ill;
    int              idx;
    if (!ex_valid || ex_flush || ex_stall) return;
    if (!(ex_is_jalr || ex_is_jal || ex_is_branch)) return;
    ill = 0;
    tk  = 1;
    if (ex_is_jalr) tgt = (ex_rs1 + ex_imm) & ~64'd1;
    else            tgt = ex_pc + ex_imm;
    if (!ex_is_jalr && !ex_is_jal) begin
      case (ex_funct3)
        3'd0: tk = (ex_rs1 == ex_rs2);
        3'd1: tk = (ex_rs1 != ex_rs2);
        3'd4: tk = ($signed(ex_rs1) < $signed(ex_rs2));
        3'd5: tk = ($signed(ex_rs1) >= $signed(ex_rs2));
        3'd6: tk = (ex_rs1 < ex_rs2);
        3'd7: tk = (ex_rs1 >= ex_rs2);
        default: begin tk = 0; ill = 1; end
      endcase
      idx = int'((ex_pc >> 2) % BHT);
      if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
      else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
    end
    e.taken   = tk;
    e.illegal = ill;
    e.rpc     = tk ? tgt : ex_pc + 64'd4;
    e.link    = ex_pc + 64'd4;
    e.redir   = (ex_pred_taken != tk) || (tk && (ex_pred_target != tgt));
    if (m_bcnt < CMAX) m_bcnt++;
    if (e.redir && m_mcnt < CMAX) m_mcnt++;
    sb.push_back(e);
  endtask

  task automatic idle();
    ex_valid = 0; ex_stall = 0; ex_flush = 0;
    ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
  endtask

  task automatic instr(input int cls, input logic [2:0] f3, input logic [63:0] pc,
                       input logic [63:0] imm, input logic [63:0] a, input logic [63:0] b,
                       input logic pt, input logic [63:0] ptgt);
    ex_valid = 1; ex_stall = 0; ex_flush = 0;
    ex_is_branch = (cls == BR); ex_is_jal = (cls == JAL); ex_is_jalr = (cls == JALR);
    ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = a; ex_rs2 = b;
    ex_pred_taken = pt; ex_pred_target = ptgt; if_pc = pc;
  endtask

  // Entered 1 time unit after a rising edge; returns 1 unit after the next one
  task automatic step();
    #1;
    chk("if_pred_taken", if_pred_taken, 64'(m_bht[int'((if_pc >> 2) % BHT)] >= 2));
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  function automatic logic [63:0] pick_op();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the output stage presents a new result
  logic            l_rv, l_tk, l_rdv, l_ill;
  logic [XLEN-1:0] l_rpc, l_link;
  initial begin
    logic held;
    exp_t e;
    l_rv = 0; l_tk = 0; l_rdv = 0; l_ill = 0; l_rpc = '0; l_link = '0;
    forever begin
      @(posedge clk);
      held = ex_stall && !ex_flush && !rst;
      @(negedge clk);
      if (rst) begin
        l_rv = 0; l_tk = 0; l_rdv = 0; l_ill = 0; l_rpc = '0; l_link = '0;
        continue;
      end
      if (held) begin
        chk("hold_res_valid", res_valid, l_rv);
        chk("hold_res_taken", res_taken, l_tk);
        chk("hold_redirect_valid", redirect_valid, l_rdv);
        chk("hold_redirect_pc", redirect_pc, l_rpc);
        chk("hold_link_data", link_data, l_link);
        chk("hold_illegal", illegal_branch, l_ill);
      end else if (res_valid) begin
        if (sb.size() == 0) chk("spurious_res_valid", res_valid, 0);
        else begin
          e = sb.pop_front();
          chk("res_taken", res_taken, e.taken);
          chk("redirect_valid", redirect_valid, e.redir);
          chk("redirect_pc", redirect_pc, e.rpc);
          chk("link_data", link_data, e.link);
          chk("illegal_branch", illegal_branch, e.illegal);
        end
      end else begin
        chk("idle_redirect_valid", redirect_valid, 0);
        chk("idle_illegal", illegal_branch, 0);
        if (sb.size() != 0) begin
          chk("missing_res_valid", res_valid, 1);
          void'(sb.pop_front());
        end
      end
      chk("branch_cnt", branch_cnt, 64'(m_bcnt));
      chk("mispred_cnt", mispred_cnt, 64'(m_mcnt));
      l_rv = res_valid; l_tk = res_taken; l_rdv = redirect_valid;
      l_rpc = redirect_pc; l_link = link_data; l_ill = illegal_branch;
    end
  end

  initial begin
    logic [31:0] r;
    logic [63:0] imm;
    rst = 1;
    idle();
    ex_funct3 = 0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0; ex_rs2 = 0;
    ex_pred_taken = 0; ex_pred_target = 0; if_pc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_link_data", link_data, 0);
    chk("rst_branch_cnt", branch_cnt, 0);
    if_pc = 64'h0;
    #1 chk("rst_bht_0x0", if_pred_taken, 0);
    if_pc = 64'hFC;
    #1 chk("rst_bht_0xfc", if_pred_taken, 0);

    // Four taken BEQs then one not-taken at the same PC
    repeat (4) begin
      instr(BR, 3'b000, 64'h80, 64'h20, 64'd5, 64'd5, 1, 64'hA0);
      step();
    end
    instr(BR, 3'b000, 64'h80, 64'h20, 64'd5, 64'd6, 0, 64'h0);
    step();
    idle();
    #1 chk("bht_0x80_after_nt", if_pred_taken, 1);
    step();

    // Signed vs unsigned compare of -1 and 1
    instr(BR, 3'b100, 64'h100, 64'h40, '1, 64'd1, 0, 64'h0);
    step();
    instr(BR, 3'b110, 64'h100, 64'h40, '1, 64'd1, 0, 64'h0);
    step();

    // JALR target bit0 cleared, correct then wrong predicted target
    instr(JALR, 3'b000, 64'h200, 64'h10, 64'h1003, 64'd0, 1, 64'h1012);
    step();
    instr(JALR, 3'b000, 64'h200, 64'h10, 64'h1003, 64'd0, 1, 64'h1010);
    step();

    // Flush together with stall kills the instruction
    instr(BR, 3'b001, 64'h180, 64'h8, 64'd1, 64'd2, 0, 64'h0);
    ex_flush = 1; ex_stall = 1;
    step();
    idle();
    step();

    // Mispredict, then a 3-cycle stall must hold the redirect
    instr(JAL, 3'b000, 64'h300, 64'h100, 64'd0, 64'd0, 0, 64'h0);
    step();
    ex_stall = 1;
    repeat (3) step();
    idle();
    step();

    // Illegal funct3 with equal operands
    instr(BR, 3'b011, 64'h400, 64'h8, 64'd7, 64'd7, 0, 64'h0);
    step();
    idle();
    step();

    // Reset between accept and the next edge
    instr(JAL, 3'b000, 64'h500, 64'h40, 64'd0, 64'd0, 0, 64'h0);
    #2 rst = 1;
    model_reset();
    #1;
    chk("async_rst_redirect_pc", redirect_pc, 0);
    chk("async_rst_branch_cnt", branch_cnt, 0);
    chk("async_rst_mispred_cnt", mispred_cnt, 0);
    @(posedge clk);
    #1 idle();
    #5 rst = 0;
    chk("post_rst_res_valid", res_valid, 0);
    chk("post_rst_redirect_valid", redirect_valid, 0);
    chk("post_rst_link_data", link_data, 0);
    step();

    // Randomized traffic, including multi-class priority, stalls and flushes
    for (int n = 0; n < 400; n++) begin
      r   = $urandom();
      imm = {{52{r[11]}}, r[11:0]};
      instr(NONE, 3'($urandom_range(0, 7)), {54'd0, 8'($urandom_range(0, 255)), 2'b00},
            imm, pick_op(), pick_op(), 1'($urandom_range(0, 1)), 64'h0);
      ex_is_branch   = r[12];
      ex_is_jal      = r[13] & r[14];
      ex_is_jalr     = r[15] & r[16];
      ex_valid       = ($urandom_range(0, 99) < 85);
      ex_stall       = ($urandom_range(0, 99) < 15);
      ex_flush       = ($urandom_range(0, 99) < 10);
      ex_pred_target = r[17] ? ex_pc + ex_imm : ((ex_rs1 + ex_imm) & ~64'd1);
      if_pc          = {54'd0, 8'($urandom_range(0, 255)), 2'b00};
      step();
    end

    idle();
    repeat (3) step();
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
